// File: rtl/sargantana_icache_miss_ctrl_if.sv
// Bus bundle between the icache miss controller and its environment:
// the core fetch port, tag-compare and array strobes, the replacement-unit
// way handshake and the L2 refill port.
//   master : the miss controller (drives core_ready_o, strobes, L2 request)
//   slave  : the environment (core, tag arrays, replacement unit, L2)
interface sargantana_icache_miss_ctrl_if #(
  parameter int unsigned IDX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned N_WAY     = 4
);
  localparam int unsigned WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  logic                           core_req_valid_i;
  logic [IDX_WIDTH-1:0]           core_req_idx_i;
  logic [TAG_WIDTH-1:0]           core_req_tag_i;
  logic                           core_ready_o;
  logic                           kill_i;
  logic                           flush_i;
  logic                           hit_i;
  logic                           resp_valid_o;
  logic                           cache_rd_ena_o;
  logic                           cache_wr_ena_o;
  logic                           cmp_en_o;
  logic [IDX_WIDTH-1:0]           cline_index_o;
  logic                           inval_o;
  logic                           flush_busy_o;
  logic [WAY_W-1:0]               way_to_replace_d_i;
  logic [WAY_W-1:0]               way_to_replace_q_o;
  logic                           l2_req_valid_o;
  logic                           l2_req_ready_i;
  logic [TAG_WIDTH+IDX_WIDTH-1:0] l2_req_addr_o;
  logic                           l2_resp_valid_i;

  modport master (
    input  core_req_valid_i, core_req_idx_i, core_req_tag_i, kill_i, flush_i,
           hit_i, way_to_replace_d_i, l2_req_ready_i, l2_resp_valid_i,
    output core_ready_o, resp_valid_o, cache_rd_ena_o, cache_wr_ena_o,
           cmp_en_o, cline_index_o, inval_o, flush_busy_o, way_to_replace_q_o,
           l2_req_valid_o, l2_req_addr_o
  );

  modport slave (
    output core_req_valid_i, core_req_idx_i, core_req_tag_i, kill_i, flush_i,
           hit_i, way_to_replace_d_i, l2_req_ready_i, l2_resp_valid_i,
    input  core_ready_o, resp_valid_o, cache_rd_ena_o, cache_wr_ena_o,
           cmp_en_o, cline_index_o, inval_o, flush_busy_o, way_to_replace_q_o,
           l2_req_valid_o, l2_req_addr_o
  );
endinterface

// File: rtl/sargantana_icache_miss_ctrl.sv
// Instruction-cache request/miss controller: sequences fetch lookup, tag
// compare, L2 refill, refill write and full-cache invalidation sweeps, and
// holds the way-to-replace register for the replacement unit.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : master side of sargantana_icache_miss_ctrl_if (core, arrays,
//           replacement unit and L2 refill signals)
module sargantana_icache_miss_ctrl #(
  parameter int unsigned IDX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned N_WAY     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  sargantana_icache_miss_ctrl_if.master bus
);
  localparam int unsigned WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  typedef enum logic [2:0] {
    IDLE, COMPARE, MISS_REQ, MISS_WAIT, REFILL, FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 pend_q, pend_d;
  logic [WAY_W-1:0]     way_q;
  logic                 cmp_en_q;
  logic                 l2_req_valid_q;
  logic                 wr_ena_q;
  logic                 flush_q;
  logic                 accept;

  assign bus.core_ready_o = (state_q == IDLE) && !bus.flush_i;
  assign accept           = bus.core_req_valid_i && bus.core_ready_o;

  // Next-state, drop and flush-pending bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (bus.kill_i || bus.hit_i) begin
          state_d = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        // The L2 request is already visible, so it is completed; only its
        // response gets discarded.
        if (bus.kill_i || bus.flush_i) drop_d = 1'b1;
        if (bus.flush_i)               pend_d = 1'b1;
        if (bus.l2_req_ready_i)        state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (bus.kill_i || bus.flush_i) drop_d = 1'b1;
        if (bus.flush_i)               pend_d = 1'b1;
        if (bus.l2_resp_valid_i) begin
          if (drop_d) begin
            state_d = pend_d ? FLUSH : IDLE;
            cnt_d   = '0;
            drop_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        state_d = (pend_q || bus.flush_i) ? FLUSH : IDLE;
        cnt_d   = '0;
        drop_d  = 1'b0;
        pend_d  = 1'b0;
      end
      FLUSH: begin
        cnt_d = IDX_WIDTH'(cnt_q + 1'b1);
        if (cnt_q == {IDX_WIDTH{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, way register and state-decoded output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      tag_q          <= '0;
      cnt_q          <= '0;
      drop_q         <= 1'b0;
      pend_q         <= 1'b0;
      way_q          <= '0;
      cmp_en_q       <= 1'b0;
      l2_req_valid_q <= 1'b0;
      wr_ena_q       <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drop_q         <= drop_d;
      pend_q         <= pend_d;
      way_q          <= bus.way_to_replace_d_i;
      cmp_en_q       <= (state_d == COMPARE);
      l2_req_valid_q <= (state_d == MISS_REQ);
      wr_ena_q       <= (state_d == REFILL);
      flush_q        <= (state_d == FLUSH);
      if (accept) begin
        idx_q <= bus.core_req_idx_i;
        tag_q <= bus.core_req_tag_i;
      end
    end
  end

  // A hit is reported in the compare cycle itself unless the core killed it.
  assign bus.resp_valid_o   = ((state_q == COMPARE) && bus.hit_i && !bus.kill_i) || wr_ena_q;
  assign bus.cache_rd_ena_o = accept;
  assign bus.cache_wr_ena_o = wr_ena_q;
  assign bus.cmp_en_o       = cmp_en_q;
  assign bus.inval_o        = flush_q;
  assign bus.flush_busy_o   = flush_q;
  assign bus.l2_req_valid_o = l2_req_valid_q;
  assign bus.l2_req_addr_o  = {tag_q, idx_q};
  assign bus.way_to_replace_q_o = way_q;

  // Lookup uses the incoming index; the sweep uses the counter.
  always_comb begin
    bus.cline_index_o = idx_q;
    if (state_q == IDLE)       bus.cline_index_o = accept ? bus.core_req_idx_i : '0;
    else if (state_q == FLUSH) bus.cline_index_o = cnt_q;
  end
endmodule

// File: tb/tb_sargantana_icache_miss_ctrl.sv
module tb_sargantana_icache_miss_ctrl;
  localparam int unsigned IDX_WIDTH = 6;
  localparam int unsigned TAG_WIDTH = 20;
  localparam int unsigned N_WAY     = 4;
  localparam int unsigned N_SETS    = 1 << IDX_WIDTH;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [IDX_WIDTH-1:0]           exp_resp[$];
  logic [TAG_WIDTH+IDX_WIDTH-1:0] exp_l2[$];

  sargantana_icache_miss_ctrl_if #(
    .IDX_WIDTH(IDX_WIDTH), .TAG_WIDTH(TAG_WIDTH), .N_WAY(N_WAY)
  ) bus ();

  sargantana_icache_miss_ctrl #(
    .IDX_WIDTH(IDX_WIDTH), .TAG_WIDTH(TAG_WIDTH), .N_WAY(N_WAY)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops plus the strobe exclusivity check, every sampled cycle.
  task automatic mon();
    logic [IDX_WIDTH-1:0]           e_idx;
    logic [TAG_WIDTH+IDX_WIDTH-1:0] e_addr;
    chk("strobe_mutex",
        32'((bus.cache_rd_ena_o & bus.cache_wr_ena_o) | (bus.cache_rd_ena_o & bus.inval_o) |
            (bus.cache_wr_ena_o & bus.inval_o)), 32'd0);
    if (bus.resp_valid_o === 1'b1) begin
      if (exp_resp.size() > 0) begin
        e_idx = exp_resp.pop_front();
        chk("resp_idx", 32'(bus.cline_index_o), 32'(e_idx));
      end else begin
        chk("unexpected_resp", 32'(bus.resp_valid_o), 32'd0);
      end
    end
    if ((bus.l2_req_valid_o === 1'b1) && (bus.l2_req_ready_i === 1'b1)) begin
      if (exp_l2.size() > 0) begin
        e_addr = exp_l2.pop_front();
        chk("l2_addr_accept", 32'(bus.l2_req_addr_o), 32'(e_addr));
      end else begin
        chk("unexpected_l2_req", 32'(bus.l2_req_valid_o), 32'd0);
      end
    end
  endtask

  task automatic mid();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.core_req_valid_i   = 1'b0;
    bus.core_req_idx_i     = '0;
    bus.core_req_tag_i     = '0;
    bus.kill_i             = 1'b0;
    bus.flush_i            = 1'b0;
    bus.hit_i              = 1'b0;
    bus.way_to_replace_d_i = '0;
    bus.l2_req_ready_i     = 1'b0;
    bus.l2_resp_valid_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    mid();
    chk("rst_ready", 32'(bus.core_ready_o), 32'd1);
    chk("rst_rd", 32'(bus.cache_rd_ena_o), 32'd0);
    chk("rst_wr", 32'(bus.cache_wr_ena_o), 32'd0);
    chk("rst_cmp", 32'(bus.cmp_en_o), 32'd0);
    chk("rst_inval", 32'(bus.inval_o), 32'd0);
    chk("rst_resp", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_l2v", 32'(bus.l2_req_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.flush_busy_o), 32'd0);
    chk("rst_idx", 32'(bus.cline_index_o), 32'd0);
    chk("rst_way", 32'(bus.way_to_replace_q_o), 32'd0);
    adv();

    // Hit: idx 5, tag 0xABCDE
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd5;
    bus.core_req_tag_i   = 20'hABCDE;
    exp_resp.push_back(6'd5);
    mid();
    chk("hit_ready", 32'(bus.core_ready_o), 32'd1);
    chk("hit_rd", 32'(bus.cache_rd_ena_o), 32'd1);
    chk("hit_rd_idx", 32'(bus.cline_index_o), 32'd5);
    adv();
    bus.core_req_valid_i = 1'b0;
    bus.hit_i = 1'b1;
    mid();
    chk("hit_cmp", 32'(bus.cmp_en_o), 32'd1);
    chk("hit_resp", 32'(bus.resp_valid_o), 32'd1);
    chk("hit_not_ready", 32'(bus.core_ready_o), 32'd0);
    adv();
    bus.hit_i = 1'b0;
    mid();
    chk("hit_ready_after", 32'(bus.core_ready_o), 32'd1);
    chk("hit_cmp_off", 32'(bus.cmp_en_o), 32'd0);
    adv();

    // Miss with L2 backpressure, way register tracking
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd5;
    bus.core_req_tag_i   = 20'hABCDE;
    exp_resp.push_back(6'd5);
    exp_l2.push_back({20'hABCDE, 6'd5});
    mid();
    adv();
    bus.core_req_valid_i   = 1'b0;
    bus.hit_i              = 1'b0;
    bus.way_to_replace_d_i = 2'd2;
    mid();
    chk("miss_cmp", 32'(bus.cmp_en_o), 32'd1);
    chk("miss_no_resp", 32'(bus.resp_valid_o), 32'd0);
    adv();
    bus.l2_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("miss_l2v_bp", 32'(bus.l2_req_valid_o), 32'd1);
      chk("miss_addr_bp", 32'(bus.l2_req_addr_o), 32'({20'hABCDE, 6'd5}));
      if (i == 0) chk("way_track", 32'(bus.way_to_replace_q_o), 32'd2);
      adv();
    end
    bus.l2_req_ready_i = 1'b1;
    mid();
    chk("miss_l2v_hs", 32'(bus.l2_req_valid_o), 32'd1);
    adv();
    bus.l2_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("miss_wait_l2v", 32'(bus.l2_req_valid_o), 32'd0);
      chk("miss_wait_wr", 32'(bus.cache_wr_ena_o), 32'd0);
      adv();
    end
    bus.l2_resp_valid_i = 1'b1;
    mid();
    adv();
    bus.l2_resp_valid_i    = 1'b0;
    bus.way_to_replace_d_i = 2'd3;
    mid();
    chk("refill_wr", 32'(bus.cache_wr_ena_o), 32'd1);
    chk("refill_resp", 32'(bus.resp_valid_o), 32'd1);
    chk("refill_way", 32'(bus.way_to_replace_q_o), 32'd2);
    chk("refill_idx", 32'(bus.cline_index_o), 32'd5);
    adv();
    mid();
    chk("refill_one_cycle", 32'(bus.cache_wr_ena_o), 32'd0);
    chk("refill_ready_after", 32'(bus.core_ready_o), 32'd1);
    chk("way_track2", 32'(bus.way_to_replace_q_o), 32'd3);
    adv();

    // Kill in COMPARE with a hit: no response
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd7;
    bus.core_req_tag_i   = 20'h00001;
    mid();
    adv();
    bus.core_req_valid_i = 1'b0;
    bus.hit_i  = 1'b1;
    bus.kill_i = 1'b1;
    mid();
    chk("kill_cmp_resp", 32'(bus.resp_valid_o), 32'd0);
    adv();
    bus.hit_i  = 1'b0;
    bus.kill_i = 1'b0;
    mid();
    chk("kill_cmp_idle", 32'(bus.core_ready_o), 32'd1);
    adv();

    // Kill in MISS_WAIT: response discarded
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd9;
    bus.core_req_tag_i   = 20'h12345;
    exp_l2.push_back({20'h12345, 6'd9});
    mid();
    adv();
    bus.core_req_valid_i = 1'b0;
    mid();
    adv();
    bus.l2_req_ready_i = 1'b1;
    mid();
    adv();
    bus.l2_req_ready_i = 1'b0;
    bus.kill_i = 1'b1;
    mid();
    adv();
    bus.kill_i = 1'b0;
    bus.l2_resp_valid_i = 1'b1;
    mid();
    adv();
    bus.l2_resp_valid_i = 1'b0;
    mid();
    chk("kill_wait_wr", 32'(bus.cache_wr_ena_o), 32'd0);
    chk("kill_wait_resp", 32'(bus.resp_valid_o), 32'd0);
    chk("kill_wait_idle", 32'(bus.core_ready_o), 32'd1);
    adv();

    // Flush from IDLE: 64 contiguous invalidations
    bus.flush_i = 1'b1;
    bus.core_req_valid_i = 1'b1;
    mid();
    chk("flush_blocks_ready", 32'(bus.core_ready_o), 32'd0);
    chk("flush_blocks_rd", 32'(bus.cache_rd_ena_o), 32'd0);
    adv();
    bus.flush_i = 1'b0;
    bus.core_req_valid_i = 1'b0;
    for (int i = 0; i < int'(N_SETS); i++) begin
      mid();
      chk("flush_inval", 32'(bus.inval_o), 32'd1);
      chk("flush_idx", 32'(bus.cline_index_o), 32'(i));
      chk("flush_busy", 32'(bus.flush_busy_o), 32'd1);
      adv();
    end
    mid();
    chk("flush_end_inval", 32'(bus.inval_o), 32'd0);
    chk("flush_end_busy", 32'(bus.flush_busy_o), 32'd0);
    chk("flush_end_ready", 32'(bus.core_ready_o), 32'd1);
    adv();

    // Flush during MISS_REQ: request completes, response dropped, then sweep
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd3;
    bus.core_req_tag_i   = 20'h0F0F0;
    exp_l2.push_back({20'h0F0F0, 6'd3});
    mid();
    adv();
    bus.core_req_valid_i = 1'b0;
    mid();
    adv();
    bus.flush_i = 1'b1;
    mid();
    chk("fm_l2v", 32'(bus.l2_req_valid_o), 32'd1);
    adv();
    bus.flush_i = 1'b0;
    bus.l2_req_ready_i = 1'b1;
    mid();
    chk("fm_l2v_held", 32'(bus.l2_req_valid_o), 32'd1);
    chk("fm_no_early_flush", 32'(bus.flush_busy_o), 32'd0);
    adv();
    bus.l2_req_ready_i = 1'b0;
    mid();
    adv();
    mid();
    adv();
    bus.l2_resp_valid_i = 1'b1;
    mid();
    chk("fm_wait_busy", 32'(bus.flush_busy_o), 32'd0);
    adv();
    bus.l2_resp_valid_i = 1'b0;
    for (int i = 0; i < int'(N_SETS); i++) begin
      mid();
      chk("fm_inval", 32'(bus.inval_o), 32'd1);
      chk("fm_idx", 32'(bus.cline_index_o), 32'(i));
      chk("fm_no_wr", 32'(bus.cache_wr_ena_o), 32'd0);
      adv();
    end
    mid();
    chk("fm_end_ready", 32'(bus.core_ready_o), 32'd1);
    chk("fm_end_busy", 32'(bus.flush_busy_o), 32'd0);
    adv();

    // Reset in MISS_WAIT, late response afterwards
    bus.core_req_valid_i = 1'b1;
    bus.core_req_idx_i   = 6'd11;
    bus.core_req_tag_i   = 20'h77777;
    exp_l2.push_back({20'h77777, 6'd11});
    mid();
    adv();
    bus.core_req_valid_i = 1'b0;
    mid();
    adv();
    bus.l2_req_ready_i = 1'b1;
    mid();
    adv();
    bus.l2_req_ready_i = 1'b0;
    mid();
    adv();
    rst = 1'b1;
    bus.way_to_replace_d_i = 2'd1;
    mid();
    adv();
    rst = 1'b0;
    bus.l2_resp_valid_i = 1'b1;
    mid();
    chk("rr_wr", 32'(bus.cache_wr_ena_o), 32'd0);
    chk("rr_resp", 32'(bus.resp_valid_o), 32'd0);
    chk("rr_ready", 32'(bus.core_ready_o), 32'd1);
    chk("rr_l2v", 32'(bus.l2_req_valid_o), 32'd0);
    chk("rr_busy", 32'(bus.flush_busy_o), 32'd0);
    chk("rr_cmp", 32'(bus.cmp_en_o), 32'd0);
    chk("rr_idx", 32'(bus.cline_index_o), 32'd0);
    chk("rr_way", 32'(bus.way_to_replace_q_o), 32'd0);
    adv();
    bus.l2_resp_valid_i = 1'b0;
    mid();
    chk("rr_late_wr", 32'(bus.cache_wr_ena_o), 32'd0);
    chk("rr_late_resp", 32'(bus.resp_valid_o), 32'd0);
    chk("rr_late_ready", 32'(bus.core_ready_o), 32'd1);
    chk("rr_way_resume", 32'(bus.way_to_replace_q_o), 32'd1);
    adv();

    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    chk("l2_queue_empty", 32'(exp_l2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
